// File: rtl/brick_mem_arbiter.sv
// Brick health RAM arbiter: fixed priority load > hit > read, one access in flight.
// Optional live-brick tally enabled by defining BRICK_TALLY_EN.
module brick_mem_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int HEALTH_W = 2
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                load_req,
    input  logic [ADDR_W-1:0]   load_addr,
    input  logic [HEALTH_W-1:0] load_health,
    output logic                load_gnt,
    input  logic                hit_req,
    input  logic [ADDR_W-1:0]   hit_addr,
    output logic                hit_gnt,
    output logic                hit_done,
    output logic [HEALTH_W-1:0] hit_health_old,
    input  logic                rd_req,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                rd_gnt,
    output logic                rd_valid,
    output logic [HEALTH_W-1:0] rd_health,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [HEALTH_W-1:0] mem_wdata,
    output logic                mem_we,
    input  logic [HEALTH_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0]   bricks_left,
    output logic                level_clear
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_WR,
        S_HIT_RD,
        S_HIT_WAIT,
        S_HIT_WR,
        S_RD,
        S_RD_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    // Holds the load health for a write, or the captured old health for a hit.
    logic [HEALTH_W-1:0] data_q, data_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value; blocking here would create ordering races.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block is given a default first, so no
        // path through the case statement can infer a latch.
        state_d        = state_q;
        addr_d         = addr_q;
        data_d         = data_q;
        load_gnt       = 1'b0;
        hit_gnt        = 1'b0;
        rd_gnt         = 1'b0;
        hit_done       = 1'b0;
        hit_health_old = '0;
        rd_valid       = 1'b0;
        rd_health      = '0;
        mem_addr       = '0;
        mem_wdata      = '0;
        mem_we         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Grants are combinational, so they are masked while reset is
                // held to keep every output low during reset.
                if (resetn && load_req) begin
                    load_gnt = 1'b1;
                    addr_d   = load_addr;
                    data_d   = load_health;
                    state_d  = S_LOAD_WR;
                end else if (resetn && hit_req) begin
                    hit_gnt = 1'b1;
                    addr_d  = hit_addr;
                    state_d = S_HIT_RD;
                end else if (resetn && rd_req) begin
                    rd_gnt  = 1'b1;
                    addr_d  = rd_addr;
                    state_d = S_RD;
                end
            end
            S_LOAD_WR: begin
                mem_addr  = addr_q;
                mem_wdata = data_q;
                mem_we    = 1'b1;
                state_d   = S_IDLE;
            end
            S_HIT_RD: begin
                mem_addr = addr_q;
                state_d  = S_HIT_WAIT;
            end
            S_HIT_WAIT: begin
                mem_addr = addr_q;
                data_d   = mem_rdata;
                state_d  = S_HIT_WR;
            end
            S_HIT_WR: begin
                mem_addr       = addr_q;
                hit_done       = 1'b1;
                hit_health_old = data_q;
                // A destroyed brick stays at zero rather than wrapping to max.
                if (data_q != '0) begin
                    mem_we    = 1'b1;
                    mem_wdata = data_q - HEALTH_W'(1);
                end
                state_d = S_IDLE;
            end
            S_RD: begin
                mem_addr = addr_q;
                state_d  = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                mem_addr  = addr_q;
                rd_valid  = 1'b1;
                rd_health = mem_rdata;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef BRICK_TALLY_EN
    logic              tally_inc, tally_dec;
    logic [ADDR_W-1:0] bricks_q, bricks_d;
    logic              clear_q, clear_d;

    assign tally_inc = (state_q == S_LOAD_WR) && (data_q != '0);
    assign tally_dec = (state_q == S_HIT_WR) && (data_q == HEALTH_W'(1));

    always_comb begin
        bricks_d = bricks_q;
        clear_d  = 1'b0;
        if (tally_inc && (bricks_q != '1)) begin
            bricks_d = bricks_q + ADDR_W'(1);
        end else if (tally_dec && (bricks_q != '0)) begin
            bricks_d = bricks_q - ADDR_W'(1);
            clear_d  = (bricks_q == ADDR_W'(1));
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bricks_q <= '0;
            clear_q  <= 1'b0;
        end else begin
            bricks_q <= bricks_d;
            clear_q  <= clear_d;
        end
    end

    assign bricks_left = bricks_q;
    assign level_clear = clear_q;
`else
    assign bricks_left = '0;
    assign level_clear = 1'b0;
`endif

endmodule

// File: tb/tb_brick_mem_arbiter.sv
// Directed bench for brick_mem_arbiter with a behavioural 1-cycle-latency RAM.
module tb_brick_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        load_req, hit_req, rd_req;
    logic [9:0]  load_addr, hit_addr, rd_addr;
    logic [1:0]  load_health;
    logic        load_gnt, hit_gnt, hit_done, rd_gnt, rd_valid;
    logic [1:0]  hit_health_old, rd_health;
    logic [9:0]  mem_addr;
    logic [1:0]  mem_wdata;
    logic        mem_we;
    logic [1:0]  mem_rdata;
    logic [9:0]  bricks_left;
    logic        level_clear;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int lc_cnt = 0;

`ifdef BRICK_TALLY_EN
    localparam bit TALLY = 1'b1;
`else
    localparam bit TALLY = 1'b0;
`endif

    bit [1:0] ram [1024];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    always @(negedge clk) begin
        if (mem_we) we_cnt++;
        if (level_clear) lc_cnt++;
    end

    logic [32:0] all_outs;
    assign all_outs = {load_gnt, hit_gnt, hit_done, hit_health_old, rd_gnt, rd_valid,
                       rd_health, mem_addr, mem_wdata, mem_we, bricks_left, level_clear};

    brick_mem_arbiter #(.ADDR_W(10), .HEALTH_W(2)) dut (
        .clk(clk), .resetn(resetn),
        .load_req(load_req), .load_addr(load_addr), .load_health(load_health), .load_gnt(load_gnt),
        .hit_req(hit_req), .hit_addr(hit_addr), .hit_gnt(hit_gnt), .hit_done(hit_done),
        .hit_health_old(hit_health_old),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_health(rd_health),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .bricks_left(bricks_left), .level_clear(level_clear)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind 0 = load, 1 = hit, 2 = read. lat = cycles from grant to done/valid, -1 on timeout.
    task automatic do_access(input int kind, input logic [9:0] addr, input logic [1:0] h,
                             output int lat, output logic [1:0] data);
        bit got;
        lat  = -1;
        data = '0;
        got  = 1'b0;
        case (kind)
            0: begin load_req = 1'b1; load_addr = addr; load_health = h; end
            1: begin hit_req = 1'b1; hit_addr = addr; end
            default: begin rd_req = 1'b1; rd_addr = addr; end
        endcase
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            got = (kind == 0) ? load_gnt : (kind == 1) ? hit_gnt : rd_gnt;
            tick();
            if (got) break;
        end
        load_req = 1'b0;
        hit_req  = 1'b0;
        rd_req   = 1'b0;
        if (!got) return;
        if (kind == 0) begin
            tick();
            lat = 1;
            return;
        end
        for (int n = 1; n < 10; n++) begin
            @(negedge clk);
            if (kind == 1 && hit_done) begin lat = n; data = hit_health_old; end
            if (kind == 2 && rd_valid) begin lat = n; data = rd_health; end
            tick();
            if (lat >= 0) break;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (all_outs !== 33'd0) begin errors++; $display("FAIL reset_outs: got %h expected 0", all_outs); end
        load_req = 1'b1;
        @(negedge clk);
        checks++; if (load_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt_masked: got %b expected 0", load_gnt); end
        tick();
        load_req = 1'b0;
        resetn   = 1'b1;
        @(negedge clk);
        checks++; if (all_outs !== 33'd0) begin errors++; $display("FAIL idle_outs: got %h expected 0", all_outs); end
        tick();
    endtask

    task automatic test_load();
        load_req = 1'b1; load_addr = 10'd5; load_health = 2'd3;
        @(negedge clk);
        checks++; if (load_gnt !== 1'b1) begin errors++; $display("FAIL load_gnt: got %b expected 1", load_gnt); end
        checks++; if ({hit_gnt, rd_gnt, mem_we} !== 3'b000) begin errors++; $display("FAIL load_t0_other: got %b expected 000", {hit_gnt, rd_gnt, mem_we}); end
        tick();
        load_req = 1'b0;
        @(negedge clk);
        checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 10'd5, 2'd3}) begin errors++; $display("FAIL load_write: got we=%b addr=%0d wdata=%0d expected we=1 addr=5 wdata=3", mem_we, mem_addr, mem_wdata); end
        checks++; if (load_gnt !== 1'b0) begin errors++; $display("FAIL load_gnt_pulse: got %b expected 0", load_gnt); end
        tick();
        @(negedge clk);
        checks++; if ({mem_we, mem_addr, mem_wdata} !== 13'd0) begin errors++; $display("FAIL load_back_idle: got we=%b addr=%0d wdata=%0d expected all 0", mem_we, mem_addr, mem_wdata); end
        tick();
    endtask

    task automatic test_hit();
        hit_req = 1'b1; hit_addr = 10'd5;
        @(negedge clk);
        checks++; if (hit_gnt !== 1'b1) begin errors++; $display("FAIL hit_gnt: got %b expected 1", hit_gnt); end
        tick();
        hit_req = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            checks++; if ({mem_addr, mem_we, hit_done} !== {10'd5, 1'b0, 1'b0}) begin errors++; $display("FAIL hit_c%0d: got addr=%0d we=%b done=%b expected addr=5 we=0 done=0", c, mem_addr, mem_we, hit_done); end
            tick();
        end
        @(negedge clk);
        checks++; if ({hit_done, hit_health_old, mem_we, mem_addr, mem_wdata} !== {1'b1, 2'd3, 1'b1, 10'd5, 2'd2}) begin errors++; $display("FAIL hit_wr: got done=%b old=%0d we=%b addr=%0d wdata=%0d expected done=1 old=3 we=1 addr=5 wdata=2", hit_done, hit_health_old, mem_we, mem_addr, mem_wdata); end
        tick();
        @(negedge clk);
        checks++; if ({hit_done, mem_we} !== 2'b00) begin errors++; $display("FAIL hit_after: got done=%b we=%b expected 0 0", hit_done, mem_we); end
        tick();
    endtask

    task automatic test_hit_zero();
        int lat, we0;
        logic [1:0] old;
        do_access(0, 10'd7, 2'd0, lat, old);
        we0 = we_cnt;
        do_access(1, 10'd7, 2'd0, lat, old);
        checks++; if (lat !== 3) begin errors++; $display("FAIL hit0_latency: got %0d expected 3", lat); end
        checks++; if (old !== 2'd0) begin errors++; $display("FAIL hit0_old: got %0d expected 0", old); end
        checks++; if (we_cnt !== we0) begin errors++; $display("FAIL hit0_no_write: got %0d writes expected 0", we_cnt - we0); end
    endtask

    task automatic test_priority();
        int load_c = -1, hit_c = -1, rd_c = -1, hd_c = -1, rv_c = -1, multi = 0;
        logic [1:0] rv_h = '0, hd_old = '0;
        load_req = 1'b1; load_addr = 10'd10; load_health = 2'd2;
        hit_req  = 1'b1; hit_addr  = 10'd5;
        rd_req   = 1'b1; rd_addr   = 10'd10;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (int'(load_gnt) + int'(hit_gnt) + int'(rd_gnt) > 1) multi++;
            if (load_gnt) load_c = c;
            if (hit_gnt)  hit_c  = c;
            if (rd_gnt)   rd_c   = c;
            if (hit_done) begin hd_c = c; hd_old = hit_health_old; end
            if (rd_valid) begin rv_c = c; rv_h = rd_health; end
            tick();
            if (load_c >= 0) load_req = 1'b0;
            if (hit_c >= 0)  hit_req  = 1'b0;
            if (rd_c >= 0)   rd_req   = 1'b0;
        end
        checks++; if (multi !== 0) begin errors++; $display("FAIL prio_multi_gnt: got %0d cycles expected 0", multi); end
        checks++; if ({load_c, hit_c, rd_c} !== {32'sd0, 32'sd2, 32'sd6}) begin errors++; $display("FAIL prio_order: got load=%0d hit=%0d rd=%0d expected 0 2 6", load_c, hit_c, rd_c); end
        checks++; if ({hd_c, 30'd0, hd_old} !== {32'sd5, 32'd2}) begin errors++; $display("FAIL prio_hit_done: got cycle=%0d old=%0d expected 5 2", hd_c, hd_old); end
        checks++; if ({rv_c, 30'd0, rv_h} !== {32'sd8, 32'd2}) begin errors++; $display("FAIL prio_rd_valid: got cycle=%0d health=%0d expected 8 2", rv_c, rv_h); end
    endtask

    task automatic test_reset_abort();
        int we0, bad = 0, lat;
        logic [1:0] h;
        hit_req = 1'b1; hit_addr = 10'd5;
        @(negedge clk);
        checks++; if (hit_gnt !== 1'b1) begin errors++; $display("FAIL abort_gnt: got %b expected 1", hit_gnt); end
        tick();
        hit_req = 1'b0;
        tick();
        we0    = we_cnt;
        resetn = 1'b0;
        @(negedge clk);
        checks++; if (all_outs !== 33'd0) begin errors++; $display("FAIL abort_outs: got %h expected 0", all_outs); end
        tick();
        tick();
        resetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (hit_done || mem_we) bad++;
            tick();
        end
        checks++; if ({bad, we_cnt - we0} !== 64'd0) begin errors++; $display("FAIL abort_no_effect: got %0d done/we cycles %0d writes expected 0 0", bad, we_cnt - we0); end
        do_access(2, 10'd5, 2'd0, lat, h);
        checks++; if ({lat, 30'd0, h} !== {32'sd2, 32'd1}) begin errors++; $display("FAIL abort_readback: got lat=%0d health=%0d expected 2 1", lat, h); end
    endtask

    task automatic test_back_to_back();
        int g[2] = '{-1, -1};
        int v[2] = '{-1, -1};
        logic [1:0] d[2] = '{2'd0, 2'd0};
        int ng = 0, nv = 0;
        rd_req = 1'b1; rd_addr = 10'd5;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (rd_gnt && ng < 2) begin g[ng] = c; ng++; end
            if (rd_valid && nv < 2) begin v[nv] = c; d[nv] = rd_health; nv++; end
            tick();
            if (ng == 1) rd_addr = 10'd10;
            if (ng == 2) rd_req = 1'b0;
        end
        checks++; if ({g[0], g[1]} !== {32'sd0, 32'sd3}) begin errors++; $display("FAIL b2b_gnt: got %0d %0d expected 0 3", g[0], g[1]); end
        checks++; if ({v[0], v[1]} !== {32'sd2, 32'sd5}) begin errors++; $display("FAIL b2b_valid: got %0d %0d expected 2 5", v[0], v[1]); end
        checks++; if ({d[0], d[1]} !== {2'd1, 2'd2}) begin errors++; $display("FAIL b2b_data: got %0d %0d expected 1 2", d[0], d[1]); end
    endtask

    task automatic test_tally();
        int lat, lc0;
        logic [1:0] old;
        lc0 = lc_cnt;
        @(negedge clk);
        checks++; if (bricks_left !== 10'd0) begin errors++; $display("FAIL tally_start: got %0d expected 0", bricks_left); end
        tick();
        do_access(0, 10'd20, 2'd1, lat, old);
        do_access(0, 10'd21, 2'd1, lat, old);
        @(negedge clk);
        checks++; if (bricks_left !== (TALLY ? 10'd2 : 10'd0)) begin errors++; $display("FAIL tally_loaded: got %0d expected %0d", bricks_left, TALLY ? 2 : 0); end
        tick();
        do_access(1, 10'd20, 2'd0, lat, old);
        @(negedge clk);
        checks++; if ({lat, 30'd0, old} !== {32'sd3, 32'd1}) begin errors++; $display("FAIL tally_hit1: got lat=%0d old=%0d expected 3 1", lat, old); end
        checks++; if ({bricks_left, level_clear} !== {(TALLY ? 10'd1 : 10'd0), 1'b0}) begin errors++; $display("FAIL tally_after_hit1: got left=%0d clear=%b expected %0d 0", bricks_left, level_clear, TALLY ? 1 : 0); end
        tick();
        do_access(1, 10'd21, 2'd0, lat, old);
        @(negedge clk);
        checks++; if ({bricks_left, level_clear} !== {10'd0, TALLY}) begin errors++; $display("FAIL tally_after_hit2: got left=%0d clear=%b expected 0 %b", bricks_left, level_clear, TALLY); end
        tick();
        tick();
        checks++; if (lc_cnt - lc0 !== (TALLY ? 1 : 0)) begin errors++; $display("FAIL tally_clear_count: got %0d expected %0d", lc_cnt - lc0, TALLY ? 1 : 0); end
    endtask

    initial begin
        resetn      = 1'b0;
        load_req    = 1'b0;
        hit_req     = 1'b0;
        rd_req      = 1'b0;
        load_addr   = '0;
        hit_addr    = '0;
        rd_addr     = '0;
        load_health = '0;
        test_reset();
        test_load();
        test_hit();
        test_hit_zero();
        test_priority();
        test_reset_abort();
        test_back_to_back();
        test_tally();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
